// File: rtl/cache_bus_arbiter.sv
// Merges the I-cache and D-cache miss ports onto one sram-like master port, one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed data priority for alternation on contention.
module cache_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [DATA_WIDTH-1:0] inst_wdata,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;     // 0 = inst, 1 = data
    cmd_t   cmd, cmd_nxt;
    logic   grant_data;
    logic   addr_ok, data_ok;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    // On contention the side that did not own the last completed transaction wins.
    assign grant_data = data_req & (~inst_req | ~last_owner);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_owner <= 1'b0;
        else if (data_ok)
            last_owner <= owner;
    end
`else
    assign grant_data = data_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            cmd   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cmd   <= cmd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cmd_nxt   = cmd;
        bus_req   = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (data_req || inst_req) begin
                    owner_nxt = grant_data;
                    cmd_nxt   = grant_data ? cmd_t'{data_wr, data_size, data_addr, data_wdata}
                                           : cmd_t'{inst_wr, inst_size, inst_addr, inst_wdata};
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                bus_req = 1'b1;
                addr_ok = bus_addr_ok;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        data_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    data_ok   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The command always comes from the latched copy so a requester may drop req mid-transaction.
    assign bus_wr       = cmd.wr;
    assign bus_size     = cmd.size;
    assign bus_addr     = cmd.addr;
    assign bus_wdata    = cmd.wdata;

    assign inst_addr_ok = addr_ok & ~owner;
    assign data_addr_ok = addr_ok &  owner;
    assign inst_data_ok = data_ok & ~owner;
    assign data_data_ok = data_ok &  owner;

    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, busy;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    // Per-cycle pulse counters, enabled only while a scenario wants them.
    logic mon_en = 1'b0;
    int   busy_n, iaok_n, idok_n, daok_n, ddok_n;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy)         busy_n++;
            if (inst_addr_ok) iaok_n++;
            if (inst_data_ok) idok_n++;
            if (data_addr_ok) daok_n++;
            if (data_data_ok) ddok_n++;
        end
    end

    cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_rdata = 0; bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    task automatic reset_counters();
        busy_n = 0; iaok_n = 0; idok_n = 0; daok_n = 0; ddok_n = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if ({busy, bus_req} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_req got %b want 00", {busy, bus_req});
        end
        checks++;
        if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin
            errors++; $display("FAIL reset_oks got %b want 0000",
                               {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
        end
        checks++;
        if (bus_addr !== 32'h0) begin
            errors++; $display("FAIL reset_cmd got %h want 00000000", bus_addr);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_inst_read();
        reset_counters();
        mon_en = 1'b1;
        inst_req = 1; inst_wr = 0; inst_size = 2'b10; inst_addr = 32'h1FC0_0000;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0) begin
            errors++; $display("FAIL iread_grant_cycle bus_req got %b want 0", bus_req);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus_req, bus_wr, bus_addr} !== {1'b1, 1'b0, 32'h1FC0_0000}) begin
            errors++; $display("FAIL iread_addr got req=%b wr=%b addr=%h want 1 0 1fc00000",
                               bus_req, bus_wr, bus_addr);
        end
        tick();
        bus_addr_ok = 1;
        @(negedge clk);
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL iread_addr_ok got %b want 10", {inst_addr_ok, data_addr_ok});
        end
        tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1A_0001;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, bus_req, inst_rdata} !== {1'b1, 1'b0, 32'h3C1A_0001}) begin
            errors++; $display("FAIL iread_data got ok=%b req=%b rdata=%h want 1 0 3c1a0001",
                               inst_data_ok, bus_req, inst_rdata);
        end
        tick();
        bus_data_ok = 0;
        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (busy_n !== 3) begin
            errors++; $display("FAIL iread_busy_cycles got %0d want 3", busy_n);
        end
        checks++;
        if ({iaok_n, idok_n, daok_n, ddok_n} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            errors++; $display("FAIL iread_pulses got ia=%0d id=%0d da=%0d dd=%0d want 1 1 0 0",
                               iaok_n, idok_n, daok_n, ddok_n);
        end
    endtask

    // Data wins the tie, then inst issues after one IDLE cycle and finishes with same-cycle oks.
    task automatic test_simultaneous();
        tick();
        inst_req = 1; inst_wr = 0; inst_addr = 32'h100; inst_size = 2'b10;
        data_req = 1; data_wr = 1; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF; data_size = 2'b01;
        tick();
        bus_addr_ok = 1;
        @(negedge clk);
        checks++;
        if ({bus_wr, bus_size, bus_addr, bus_wdata} !== {1'b1, 2'b01, 32'h200, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL sim_data_cmd got wr=%b size=%b addr=%h wdata=%h want 1 01 200 deadbeef",
                               bus_wr, bus_size, bus_addr, bus_wdata);
        end
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL sim_data_addr_ok got %b want 10", {data_addr_ok, inst_addr_ok});
        end
        tick();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            errors++; $display("FAIL sim_data_ok got %b want 10", {data_data_ok, inst_data_ok});
        end
        tick();
        bus_data_ok = 0;
        @(negedge clk);
        checks++;
        if ({busy, bus_req} !== 2'b00) begin
            errors++; $display("FAIL sim_idle_gap got busy=%b req=%b want 0 0", busy, bus_req);
        end
        tick();
        bus_addr_ok = 1; bus_data_ok = 1;
        @(negedge clk);
        checks++;
        if ({bus_req, bus_wr, bus_addr} !== {1'b1, 1'b0, 32'h100}) begin
            errors++; $display("FAIL sim_inst_cmd got req=%b wr=%b addr=%h want 1 0 100",
                               bus_req, bus_wr, bus_addr);
        end
        checks++;
        if ({inst_addr_ok, inst_data_ok, data_data_ok} !== 3'b110) begin
            errors++; $display("FAIL same_cycle_oks got %b want 110",
                               {inst_addr_ok, inst_data_ok, data_data_ok});
        end
        tick();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL same_cycle_no_wait busy got %b want 0", busy);
        end
    endtask

    task automatic test_drop_req();
        tick();
        data_req = 1; data_wr = 0; data_addr = 32'h300;
        tick();
        data_req = 0; data_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus_req, bus_addr, data_addr_ok} !== {1'b1, 32'h300, 1'b0}) begin
                errors++; $display("FAIL drop_hold[%0d] got req=%b addr=%h aok=%b want 1 300 0",
                                   i, bus_req, bus_addr, data_addr_ok);
            end
            tick();
        end
        bus_addr_ok = 1;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++; $display("FAIL drop_addr_ok got %b want 1", data_addr_ok);
        end
        tick();
        bus_addr_ok = 0; bus_data_ok = 1;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            errors++; $display("FAIL drop_data_ok got %b want 10", {data_data_ok, inst_data_ok});
        end
        tick();
        bus_data_ok = 0;
    endtask

    task automatic test_async_reset();
        tick();
        inst_req = 1; inst_addr = 32'h400;
        tick();
        bus_addr_ok = 1;
        tick();
        inst_req = 0; bus_addr_ok = 0;
        @(negedge clk);
        checks++;
        if ({busy, bus_req} !== 2'b10) begin
            errors++; $display("FAIL arst_in_wait got busy=%b req=%b want 1 0", busy, bus_req);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL arst_immediate busy got %b want 0", busy);
        end
        #1 rst = 1'b0;
        bus_data_ok = 1;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL arst_stale_now got %b want 00", {inst_data_ok, data_data_ok});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin
            errors++; $display("FAIL arst_stale_next got %b want 000",
                               {inst_data_ok, data_data_ok, busy});
        end
        tick();
        bus_data_ok = 0;
    endtask

    // Both sides request continuously with a zero-latency bridge: a grant every other cycle.
    task automatic test_back_to_back();
        logic [31:0] want;
        test_reset();
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_addr = 32'h200;
        bus_addr_ok = 1; bus_data_ok = 1;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            want = (g % 2 == 0) ? 32'h200 : 32'h100;
`else
            want = 32'h200;
`endif
            tick();
            @(negedge clk);
            checks++;
            if ({bus_req, bus_addr} !== {1'b1, want}) begin
                errors++; $display("FAIL b2b_grant[%0d] got req=%b addr=%h want 1 %h",
                                   g, bus_req, bus_addr, want);
            end
            tick();
            @(negedge clk);
            checks++;
            if ({busy, inst_data_ok, data_data_ok} !== 3'b000) begin
                errors++; $display("FAIL b2b_idle[%0d] got %b want 000",
                                   g, {busy, inst_data_ok, data_data_ok});
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_simultaneous();
        test_drop_req();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
